prf_release_queue: RTL and testbench

//  Commit-side producer for the integer free list: collects stale physical registers (old dest mappings)

---
 rtl/prf_release_queue.sv | 132 +++++++++++++
 tb/tb_prf_release_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prf_release_queue.sv
// prf_release_queue
//   Collects stale physical register indices released at commit and returns them to the
//   integer free list in order. Multi-in / multi-out circular FIFO. Valid lanes on the commit
//   side are packed together before they are written, and the output lanes are filled
//   contiguously from lane 0.
//
// Ports
//   clk_i               rising-edge clock
//   rst_i               asynchronous, active-high reset
//   commit_valid_i      per-lane release valid (any lane pattern)
//   commit_prf_old_i    per-lane stale PRF index
//   release_ready_o     queue can take a full commit group this cycle
//   hold_i              free list busy: emit nothing this cycle
//   prf_replace_valid_o output lane valids, contiguous from lane 0
//   prf_replace_o       output PRF indices, lane 0 = oldest
//   count_o             entries currently queued
//   overflow_err_o      sticky: a push was attempted while release_ready_o was low
module prf_release_queue #(
   parameter int unsigned CommitWidth = 3,
   parameter int unsigned RenameWidth = 3,
   parameter int unsigned PrfIdxW     = 6,
   parameter int unsigned Depth       = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [CommitWidth-1:0]         commit_valid_i,
   input  logic [CommitWidth*PrfIdxW-1:0] commit_prf_old_i,
   output logic                           release_ready_o,
   input  logic                           hold_i,
   output logic [RenameWidth-1:0]         prf_replace_valid_o,
   output logic [RenameWidth*PrfIdxW-1:0] prf_replace_o,
   output logic [$clog2(Depth+1)-1:0]     count_o,
   output logic                           overflow_err_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth+1);

   logic [PrfIdxW-1:0] mem_q [Depth];
   logic [PtrW-1:0]    head_q, head_d;
   logic [PtrW-1:0]    tail_q, tail_d;
   logic [CntW-1:0]    count_q, count_d;
   logic               overflow_q, overflow_d;

   logic               push_attempt;
   logic               push_accept;
   logic [CntW-1:0]    wr_cnt;
   logic [CntW-1:0]    pop_n;
   logic               lane_we   [CommitWidth];
   logic [PtrW-1:0]    lane_slot [CommitWidth];

   // Readiness depends on the current count only; entries leaving this cycle are not credited.
   assign release_ready_o = (count_q <= CntW'(Depth - CommitWidth));
   assign push_attempt    = |commit_valid_i;
   assign push_accept     = push_attempt && release_ready_o;

   // Compact the commit lanes: each surviving lane lands at tail plus the number of
   // surviving lanes below it. PRF 0 is the x0 mapping and is never returned.
   always_comb begin
      wr_cnt = '0;
      for (int l = 0; l < CommitWidth; l++) begin
         lane_we[l]   = push_accept && commit_valid_i[l] &&
                        (commit_prf_old_i[l*PrfIdxW +: PrfIdxW] != '0);
         lane_slot[l] = tail_q + PtrW'(wr_cnt);
         if (lane_we[l]) begin
            wr_cnt = wr_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      if (hold_i) begin
         pop_n = '0;
      end else if (count_q < CntW'(RenameWidth)) begin
         pop_n = count_q;
      end else begin
         pop_n = CntW'(RenameWidth);
      end
   end

   // Outputs are driven from registered entries only; there is no commit-to-output bypass.
   always_comb begin
      prf_replace_valid_o = '0;
      prf_replace_o       = '0;
      for (int i = 0; i < RenameWidth; i++) begin
         if (CntW'(i) < pop_n) begin
            prf_replace_valid_o[i]              = 1'b1;
            prf_replace_o[i*PrfIdxW +: PrfIdxW] = mem_q[head_q + PtrW'(i)];
         end
      end
   end

   // Pointers wrap naturally because Depth is a power of two.
   always_comb begin
      head_d     = head_q + PtrW'(pop_n);
      tail_d     = tail_q + PtrW'(wr_cnt);
      count_d    = count_q + wr_cnt - pop_n;
      overflow_d = overflow_q || (push_attempt && !release_ready_o);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < Depth; s++) begin
            mem_q[s] <= '0;
         end
      end else begin
         for (int l = 0; l < CommitWidth; l++) begin
            if (lane_we[l]) begin
               mem_q[lane_slot[l]] <= commit_prf_old_i[l*PrfIdxW +: PrfIdxW];
            end
         end
      end
   end

   assign count_o        = count_q;
   assign overflow_err_o = overflow_q;

endmodule

// File: tb/tb_prf_release_queue.sv
// tb_prf_release_queue
//   Scoreboard bench for prf_release_queue. The driver applies inputs just after each rising
//   edge and pushes the expected output of that cycle, taken from a plain-queue reference
//   model, into a scoreboard. The monitor pops and compares on each falling edge.
module tb_prf_release_queue;

   typedef struct packed {
      logic [2:0]  v;
      logic [17:0] d;
      logic [4:0]  cnt;
      logic        rdy;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [2:0]  commit_valid;
   logic [17:0] commit_prf_old;
   logic        release_ready;
   logic        hold;
   logic [2:0]  prf_replace_valid;
   logic [17:0] prf_replace;
   logic [4:0]  count;
   logic        overflow_err;

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   int   model[$];
   logic m_ovf;

   prf_release_queue #(
      .CommitWidth(3),
      .RenameWidth(3),
      .PrfIdxW    (6),
      .Depth      (16)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .commit_valid_i     (commit_valid),
      .commit_prf_old_i   (commit_prf_old),
      .release_ready_o    (release_ready),
      .hold_i             (hold),
      .prf_replace_valid_o(prf_replace_valid),
      .prf_replace_o      (prf_replace),
      .count_o            (count),
      .overflow_err_o     (overflow_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare the DUT against the oldest scoreboard entry each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("replace_valid", 32'(prf_replace_valid), 32'(e.v));
            check("replace_data",  32'(prf_replace),       32'(e.d));
            check("count",         32'(count),             32'(e.cnt));
            check("release_ready", 32'(release_ready),     32'(e.rdy));
            check("overflow_err",  32'(overflow_err),      32'(e.ovf));
         end
      end
   end

   // One clock of stimulus. Expected outputs come from the model before the edge is applied.
   task automatic drive_cycle(input logic h, input logic [2:0] v, input int p0, input int p1,
                              input int p2);
      int   lanes[3];
      int   n;
      exp_t e;
      lanes = '{p0, p1, p2};
      @(posedge clk);
      #1;
      hold           = h;
      commit_valid   = v;
      commit_prf_old = {6'(p2), 6'(p1), 6'(p0)};
      e   = '0;
      n   = h ? 0 : ((model.size() < 3) ? model.size() : 3);
      for (int i = 0; i < n; i++) begin
         e.v[i]         = 1'b1;
         e.d[i*6 +: 6]  = 6'(model[i]);
      end
      e.cnt = 5'(model.size());
      e.rdy = ((16 - model.size()) >= 3);
      e.ovf = m_ovf;
      exp_q.push_back(e);
      for (int i = 0; i < n; i++) begin
         void'(model.pop_front());
      end
      if (v != 3'b000) begin
         if (!e.rdy) begin
            m_ovf = 1'b1;
         end else begin
            for (int l = 0; l < 3; l++) begin
               if (v[l] && (lanes[l] % 64) != 0) model.push_back(lanes[l] % 64);
            end
         end
      end
   endtask

   // Asynchronous reset applied between edges; outputs must clear without a clock.
   task automatic do_reset();
      @(negedge clk);
      #1;
      rst          = 1'b1;
      hold         = 1'b0;
      commit_valid = 3'b000;
      #1;
      check("rst_valid", 32'(prf_replace_valid), 32'd0);
      check("rst_data",  32'(prf_replace),       32'd0);
      check("rst_count", 32'(count),             32'd0);
      check("rst_ready", 32'(release_ready),     32'd1);
      check("rst_ovf",   32'(overflow_err),      32'd0);
      model.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) drive_cycle(1'b0, 3'b000, 0, 0, 0);
   endtask

   initial begin
      int wait_cnt;
      rst            = 1'b1;
      hold           = 1'b0;
      commit_valid   = 3'b000;
      commit_prf_old = '0;
      m_ovf          = 1'b0;
      do_reset();

      // Full group, then a sparse group, then a group with the x0 mapping.
      drive_cycle(1'b0, 3'b111, 5, 6, 7);
      idle(2);
      drive_cycle(1'b0, 3'b101, 9, 0, 12);
      idle(2);
      drive_cycle(1'b0, 3'b011, 0, 4, 33);
      idle(2);

      // Hold blocks output while enqueue continues; order survives the hold.
      drive_cycle(1'b1, 3'b111, 1, 2, 3);
      drive_cycle(1'b1, 3'b111, 4, 5, 6);
      drive_cycle(1'b1, 3'b000, 0, 0, 0);
      idle(3);

      // Fill to 15 under hold (head is mid-array so the data wraps), then overflow.
      for (int k = 0; k < 5; k++) drive_cycle(1'b1, 3'b111, 20 + 3*k, 21 + 3*k, 22 + 3*k);
      drive_cycle(1'b1, 3'b111, 8, 9, 10);
      drive_cycle(1'b1, 3'b000, 0, 0, 0);
      idle(7);

      // Steady stream, then reset with entries in flight.
      for (int k = 0; k < 4; k++) drive_cycle(1'b0, 3'b111, 40 + k, 50 + k, 60 + k);
      do_reset();
      idle(3);

      // Randomised traffic with bursts of hold to build occupancy.
      for (int k = 0; k < 400; k++) begin
         logic h;
         h = ($urandom_range(0, 99) < ((k / 50) % 2 == 1 ? 70 : 20));
         drive_cycle(h, 3'($urandom_range(0, 7)), int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 63)), ($urandom_range(0, 7) == 0) ? 0 :
                     int'($urandom_range(1, 63)));
      end
      idle(8);

      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
